// File: rtl/sine_phase_sequencer_pkg.sv
// Shared constants and phase arithmetic for the sine phase sequencer.
package sine_phase_sequencer_pkg;

  localparam int W        = 16;
  // Quarter turn in Q.13: round(pi/2 * 2^13).
  localparam int PI2      = 12868;
  localparam int TWO_PI   = 4 * PI2;
  localparam int BUSY_TMO = 4;
  localparam int TMO_W    = $clog2(BUSY_TMO);

  localparam logic [W-1:0]     TWO_PI_W   = W'(TWO_PI);
  localparam logic [W:0]       TWO_PI_EXT = (W+1)'(TWO_PI);
  localparam logic [TMO_W-1:0] TMO_INIT   = TMO_W'(BUSY_TMO - 1);

  // Modular add; both operands are already below TWO_PI, so a single
  // conditional subtract keeps the result in range. The extra bit holds the
  // carry, since two values near 2*pi overflow 16 bits.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= TWO_PI_EXT) begin
      sum = sum - TWO_PI_EXT;
    end
    return sum[W-1:0];
  endfunction

endpackage

// File: rtl/sine_phase_sequencer_phase_accum.sv
// Phase accumulator: owns the phase and step registers, rejects out-of-range
// steps, and advances phase modulo 2*pi once per accepted sample.
module phase_accum
  import sine_phase_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] step,
  input  logic         step_load,
  input  logic         phase_clear,
  input  logic         advance,
  output logic [W-1:0] phase,
  output logic         step_err
);

  logic [W-1:0] step_r;
  logic         step_ok;

  assign step_ok = (step < TWO_PI_W);

  // Step load/validation and phase update; advance sees the pre-load step_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      step_r   <= '0;
      step_err <= 1'b0;
    end else begin
      step_err <= step_load && !step_ok;
      if (step_load && step_ok) begin
        step_r <= step;
      end
      if (phase_clear) begin
        phase <= '0;
      end else if (advance) begin
        phase <= wrap_add(phase, step_r);
      end
    end
  end

endmodule

// File: rtl/sine_phase_sequencer.sv
// Sine phase sequencer: issues one phase angle per sample to the CORDIC,
// waits out its busy period, and hands the result downstream with
// valid/ready backpressure.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | no sample in flight; phase_clear honoured here
// S_ISSUE     | latch phase into cs_angle; cs_update follows next cycle
// S_WAIT_BUSY | wait for CORDIC to drop ready; bounded by BUSY_TMO
// S_WAIT_DONE | CORDIC computing; capture result when ready returns
// S_OUTPUT    | sample_valid held until sample_ready accepts it
module sine_phase_sequencer
  import sine_phase_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] step,
  input  logic         step_load,
  input  logic         phase_clear,
  output logic         step_err,
  output logic         cs_update,
  output logic [W-1:0] cs_angle,
  input  logic         cs_ready,
  input  logic [W-1:0] cs_result,
  output logic [W-1:0] sample,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         busy_err,
  output logic [15:0]  sample_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_OUTPUT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     phase;
  logic [TMO_W-1:0] tmo_cnt;
  logic             issue;
  logic             capture;
  logic             accept;
  logic             tmo_expire;

  phase_accum u_phase_accum (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .step_load   (step_load),
    .phase_clear (phase_clear && (state == S_IDLE)),
    .advance     (accept),
    .phase       (phase),
    .step_err    (step_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and one-cycle datapath strobes.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    tmo_expire = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && cs_ready) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue     = 1'b1;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!cs_ready) begin
          state_nxt = S_WAIT_DONE;
        end else if (tmo_cnt == '0) begin
          tmo_expire = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (cs_ready) begin
          capture   = 1'b1;
          state_nxt = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (sample_ready) begin
          accept    = 1'b1;
          state_nxt = enable ? S_ISSUE : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered CORDIC request, busy timeout, result capture and sample count.
  // cs_update is registered alongside cs_angle so the CORDIC always sees the
  // new angle in the same cycle as the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_update    <= 1'b0;
      cs_angle     <= '0;
      tmo_cnt      <= '0;
      busy_err     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sample_cnt   <= '0;
    end else begin
      cs_update <= issue;
      if (issue) begin
        cs_angle <= phase;
        tmo_cnt  <= TMO_INIT;
      end else if ((state == S_WAIT_BUSY) && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (tmo_expire) begin
        busy_err <= 1'b1;
      end
      if (capture) begin
        sample       <= cs_result;
        sample_valid <= 1'b1;
      end else if (accept) begin
        sample_valid <= 1'b0;
        sample_cnt   <= sample_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Bench for sine_phase_sequencer: behavioural CORDIC (18-cycle busy) plus a
// phase/step/count reference model updated from observed handshakes.
module tb_sine_phase_sequencer;
  import sine_phase_sequencer_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [15:0]  step;
  logic         step_load;
  logic         phase_clear;
  logic         step_err;
  logic         cs_update;
  logic [15:0]  cs_angle;
  logic         cs_ready;
  logic [15:0]  cs_result;
  logic [15:0]  sample;
  logic         sample_valid;
  logic         sample_ready;
  logic         busy_err;
  logic [15:0]  sample_cnt;

  always #5 clk = ~clk;

  sine_phase_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .step         (step),
    .step_load    (step_load),
    .phase_clear  (phase_clear),
    .step_err     (step_err),
    .cs_update    (cs_update),
    .cs_angle     (cs_angle),
    .cs_ready     (cs_ready),
    .cs_result    (cs_result),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy_err     (busy_err),
    .sample_cnt   (sample_cnt)
  );

  function automatic logic [15:0] cordic_f(input logic [15:0] a);
    logic [15:0] r;
    r = a * 16'd3 + 16'd7;
    return r;
  endfunction

  // Behavioural CORDIC: latches the angle on update, busy for 18 cycles.
  int          m_cnt;
  logic [15:0] m_angle;
  bit          stuck;
  always @(posedge clk) begin
    if (reset) begin
      m_cnt     <= 0;
      cs_ready  <= 1'b1;
      cs_result <= '0;
      m_angle   <= '0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        cs_ready  <= 1'b1;
        cs_result <= cordic_f(m_angle);
      end
    end else if (cs_update && !stuck) begin
      m_angle  <= cs_angle;
      m_cnt    <= 18;
      cs_ready <= 1'b0;
    end
  end

  int          total = 0;
  int          bad = 0;
  int          exp_phase, exp_step, exp_cnt;
  int          n_upd, n_acc, cyc, first_upd_cyc;
  logic [15:0] last_angle;
  bit          err_due, clr_ok;
  int          angles[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, update the reference, then move to just
  // after the next rising edge where the caller may change inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("step_err", step_err, err_due);
    chk("sample_cnt", sample_cnt, exp_cnt);
    if (cs_update) begin
      chk("upd_while_ready", cs_ready, 1);
      chk("cs_angle", cs_angle, exp_phase);
      last_angle = 16'(exp_phase);
      angles.push_back(exp_phase);
      if (n_upd == 0) first_upd_cyc = cyc;
      n_upd++;
    end
    if (sample_valid && sample_ready) begin
      chk("sample", sample, cordic_f(last_angle));
      exp_cnt   = (exp_cnt + 1) % 65536;
      exp_phase = (exp_phase + exp_step) % TWO_PI;
      n_acc++;
    end
    err_due = step_load && (int'(step) >= TWO_PI);
    if (step_load && (int'(step) < TWO_PI)) exp_step = int'(step);
    if (phase_clear && clr_ok) exp_phase = 0;
    if (reset) begin
      exp_phase = 0; exp_step = 0; exp_cnt = 0;
      n_upd = 0; n_acc = 0; err_due = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_upd"}, cs_update, 0);
    chk({tag, "_angle"}, cs_angle, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_busy_err"}, busy_err, 0);
    chk({tag, "_cnt"}, sample_cnt, 0);
    chk({tag, "_step_err"}, step_err, 0);
  endtask

  task automatic load_step(input int v);
    step = 16'(v); step_load = 1'b1;
    tick();
    step_load = 1'b0;
  endtask

  task automatic run_upd(input int target, input string tag);
    int k = 0;
    while (n_upd < target && k < 400) begin tick(); k++; end
    chk({tag, "_upd_timeout"}, n_upd >= target, 1);
  endtask

  task automatic wait_busy(input string tag);
    int k = 0;
    while (cs_ready !== 1'b0 && k < 100) begin tick(); k++; end
    chk({tag, "_busy_timeout"}, cs_ready, 0);
  endtask

  task automatic drain(input string tag);
    enable = 1'b0; sample_ready = 1'b1;
    repeat (50) tick();
    chk({tag, "_drained"}, n_acc, n_upd);
    chk({tag, "_idle_valid"}, sample_valid, 0);
  endtask

  initial begin
    int u, a, d, k;
    reset = 1'b1; enable = 1'b0; step = '0; step_load = 1'b0;
    phase_clear = 1'b0; sample_ready = 1'b0; stuck = 1'b0; clr_ok = 1'b0;
    exp_phase = 0; exp_step = 0; exp_cnt = 0; n_upd = 0; n_acc = 0;
    cyc = 0; first_upd_cyc = 0; err_due = 0; last_angle = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check_zero("reset");

    // Quarter-turn step wraps exactly back to zero
    load_step(12868);
    angles.delete();
    enable = 1'b1; sample_ready = 1'b1;
    run_upd(5, "quarter");
    chk("quarter_a0", angles[0], 0);
    chk("quarter_a1", angles[1], 12868);
    chk("quarter_a2", angles[2], 25736);
    chk("quarter_a3", angles[3], 38604);
    chk("quarter_a4", angles[4], 0);
    drain("quarter");

    // Large step wraps with carry beyond 16 bits
    reset = 1'b1; tick(); reset = 1'b0;
    load_step(50000);
    angles.delete();
    enable = 1'b1;
    run_upd(3, "big");
    chk("big_a0", angles[0], 0);
    chk("big_a1", angles[1], 50000);
    chk("big_a2", angles[2], 48528);
    drain("big");

    // Step equal to TWO_PI is rejected, one below is accepted
    load_step(51472);
    chk("err_pulse", step_err, 1);
    tick();
    chk("err_clears", step_err, 0);
    angles.delete();
    enable = 1'b1;
    run_upd(n_upd + 2, "rej");
    chk("rej_step_kept", (angles[1] - angles[0] + TWO_PI) % TWO_PI, 50000);
    drain("rej");
    load_step(51471);
    chk("ok_no_err", step_err, 0);
    angles.delete();
    enable = 1'b1;
    run_upd(n_upd + 2, "acc");
    chk("acc_step_new", (angles[1] - angles[0] + TWO_PI) % TWO_PI, 51471);
    drain("acc");

    // Backpressure: sample held 10 cycles
    sample_ready = 1'b0; enable = 1'b1;
    k = 0;
    while (sample_valid !== 1'b1 && k < 100) begin tick(); k++; end
    chk("bp_valid_rise", sample_valid, 1);
    u = n_upd;
    repeat (10) begin
      tick();
      chk("bp_sample", sample, cordic_f(last_angle));
      chk("bp_valid", sample_valid, 1);
    end
    chk("bp_no_update", n_upd, u);
    chk("bp_cnt", sample_cnt, exp_cnt);
    drain("bp");

    // Enable dropped during WAIT_DONE: sample still delivered, no new issue
    enable = 1'b1;
    wait_busy("endrop");
    enable = 1'b0;
    u = n_upd; a = n_acc;
    repeat (60) tick();
    chk("endrop_acc", n_acc, a + 1);
    chk("endrop_upd", n_upd, u);

    // phase_clear honoured in IDLE, ignored mid-sample
    clr_ok = 1'b1; phase_clear = 1'b1;
    tick();
    phase_clear = 1'b0; clr_ok = 1'b0;
    angles.delete();
    enable = 1'b1;
    run_upd(n_upd + 1, "clr");
    chk("clr_first", angles[0], 0);
    wait_busy("clr_mid");
    phase_clear = 1'b1;
    tick();
    phase_clear = 1'b0;
    run_upd(n_upd + 2, "clr_mid");
    drain("clr");

    // Reset during WAIT_DONE
    enable = 1'b1;
    wait_busy("rstmid");
    reset = 1'b1;
    tick();
    check_zero("rstmid");
    reset = 1'b0;
    angles.delete();
    run_upd(2, "rstmid");
    chk("rstmid_a0", angles[0], 0);
    chk("rstmid_a1", angles[1], 0);
    drain("rstmid");

    // Randomised steps, backpressure and enable
    load_step(int'($urandom_range(TWO_PI - 1)));
    enable = 1'b1;
    a = n_acc;
    for (int i = 0; i < 1500; i++) begin
      sample_ready = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 2) enable = ~enable;
      if ($urandom_range(99) < 5) begin
        step_load = 1'b1;
        step = ($urandom_range(9) < 3) ? 16'($urandom_range(65535, TWO_PI))
                                       : 16'($urandom_range(TWO_PI - 1));
      end else begin
        step_load = 1'b0;
      end
      tick();
    end
    step_load = 1'b0;
    drain("rand");
    chk("rand_progress", n_acc > a + 20, 1);

    // CORDIC never goes busy: sticky busy_err
    reset = 1'b1; tick(); reset = 1'b0;
    stuck = 1'b1; enable = 1'b1;
    k = 0;
    while (busy_err !== 1'b1 && k < 40) begin tick(); k++; end
    chk("busy_err_set", busy_err, 1);
    d = cyc - first_upd_cyc;
    chk("busy_err_latency", (d >= 3) && (d <= 5), 1);
    enable = 1'b0;
    repeat (20) tick();
    chk("busy_err_sticky", busy_err, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("busy_err_reset", busy_err, 0);
    stuck = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
